// File: rtl/nibble_link_pkg.sv
// Shared definitions for the inverted 4-bit nibble link receiver.
// Latency: n/a (types, constants and the pin decode helper only).
// Backpressure: n/a.
package nibble_link_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    // Receive FSM: waiting for a low-nibble beat, or holding the low nibble
    // while waiting for the matching high-nibble beat.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HIGH = 1'b1
    } rx_state_t;

    // The link drives every nibble active-low, so the pins are re-inverted
    // on receive. Keeping this in one place lets all users agree on polarity.
    function automatic logic [NIB_W-1:0] link_decode(input logic [NIB_W-1:0] pins);
        return ~pins;
    endfunction

endpackage

// File: rtl/nibble_link_fifo.sv
// Small synchronous FIFO holding reassembled link bytes for the consumer.
// Latency: a pushed entry is on pop_dat with pop_vld high the cycle after the push.
// Backpressure: push_rdy drops when full unless a pop frees a slot in the same cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_vld/_dat/_rdy  write side; an entry is written when push_vld && push_rdy
//   pop_vld/_dat/_rdy   read side; pop_dat is always the head entry
module nibble_link_fifo
    import nibble_link_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             push_fire;
    logic             pop_fire;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_vld   = !empty;
    assign pop_fire  = pop_vld && pop_rdy;
    // When full, a same-cycle pop vacates exactly the slot the push writes
    // (write index == head index), so accepting the push keeps order intact.
    assign push_rdy  = !full || pop_fire;
    assign push_fire = push_vld && push_rdy;
    assign pop_dat   = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the output reads 0 until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_fire) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/nibble_link_rx.sv
// Receive end of the inverted nibble link: strobe sync, two-beat byte rebuild, output FIFO.
// Latency: byte valid in the SYNC_STAGES+2'th cycle counting the cycle of the high-beat strb toggle.
// Backpressure: dout_valid/dout_ready; bytes arriving to a full FIFO are dropped and flag overrun.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   nib_n, strb, first link pins (inverted data, toggle strobe, low-beat flag)
//   dout, dout_valid, dout_ready   received byte stream {high, low}
//   overrun, frame_err, err_clr    sticky error flags and their synchronous clear
module nibble_link_rx
    import nibble_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIB_W-1:0]  nib_n,
    input  logic              strb,
    input  logic              first,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overrun,
    output logic              frame_err,
    input  logic              err_clr
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   strb_hist;
    logic                   beat;

    rx_state_t              state;
    logic [NIB_W-1:0]       lo_nib;
    logic [CNT_W-1:0]       cnt;
    logic                   timeout_hit;

    logic                   push_vld;
    logic [BYTE_W-1:0]      push_dat;
    logic                   push_rdy;
    logic                   frame_evt;
    logic                   overrun_evt;

    // Strobe synchroniser plus history flop; either strobe edge is one beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            strb_hist <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], strb};
            strb_hist <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign beat     = sync_out ^ strb_hist;

    // nib_n and first are sampled raw on the beat cycle: the transmitter holds
    // them stable well past the point where the synchronised strobe arrives.
    assign timeout_hit = (state == HIGH) && !beat && (cnt == CNT_W'(TIMEOUT));
    assign push_vld    = (state == HIGH) && beat && !first;
    assign push_dat    = {link_decode(nib_n), lo_nib};
    assign frame_evt   = ((state == IDLE) && beat && !first)
                       || ((state == HIGH) && beat && first)
                       || timeout_hit;
    assign overrun_evt = push_vld && !push_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lo_nib <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat && first) begin
                        lo_nib <= link_decode(nib_n);
                        cnt    <= '0;
                        state  <= HIGH;
                    end
                end
                HIGH: begin
                    if (beat) begin
                        if (first) begin
                            // A new low beat restarts the frame with the new nibble.
                            lo_nib <= link_decode(nib_n);
                            cnt    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a new event in the clear cycle wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_evt) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    nibble_link_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (dout_valid),
        .pop_dat  (dout),
        .pop_rdy  (dout_ready)
    );

endmodule

// File: doc/nibble_link_rx.md
Name: nibble_link_rx

Overview:
- Receive end of the 4-bit inverted nibble link. The transmit side drives each data nibble active-low on four pins and passes a toggle strobe and a first-beat flag straight through.
- This block synchronises the strobe and captures two beats, low nibble first.
- It re-inverts the data, rebuilds the byte and buffers it in a small FIFO with a valid/ready output.
- It sits behind the user-module pin map and feeds on-chip logic.

Parameters:
- SYNC_STAGES, 2, flops in the strobe synchroniser (minimum 2).
- TIMEOUT, 255, cycles allowed between the low-nibble beat and the high-nibble beat before the partial byte is dropped (minimum 1).
- FIFO_DEPTH, 2, output FIFO entries (power of 2, minimum 2).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- nib_n  input  4  link data, active-low (pin value = ~nibble).
- strb  input  1  toggles once per beat; asynchronous to clk.
- first  input  1  high on the low-nibble beat, low on the high-nibble beat.
- dout  output  8  received byte, {high nibble, low nibble}.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer accepts dout when high together with dout_valid.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: timeout occurred, or a beat arrived with an unexpected first value.
- err_clr  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset is asynchronous on rst_n low. It clears the synchroniser, edge register, FSM (to IDLE), timeout counter, FIFO pointers, overrun and frame_err. dout reads 0 and dout_valid is 0.
- Beat detect:
  - strb passes through SYNC_STAGES flops plus one history flop.
  - beat = sync_out XOR history.
  - nib_n and first are sampled on the beat cycle without their own synchroniser. The transmitter holds them stable from at least 1 cycle before a strb toggle until SYNC_STAGES+2 cycles after it.
- FSM with two states:
  - IDLE, beat && first: lo <= ~nib_n, go to HIGH, counter <= 0.
  - IDLE, beat && !first: set frame_err, stay in IDLE.
  - HIGH, beat && !first: form the byte {~nib_n, lo} and push it to the FIFO, go to IDLE.
  - HIGH, beat && first: set frame_err, discard the old lo, lo <= ~nib_n, stay in HIGH, counter <= 0 (resync to the new frame).
  - HIGH, no beat: counter increments. When counter == TIMEOUT, set frame_err and go to IDLE.
- FIFO:
  - Push occurs on the cycle the high beat is detected; the byte is visible on dout the next cycle with dout_valid = 1.
  - Latency from the high-nibble strb toggle at the pin to dout_valid is SYNC_STAGES+2 cycles.
  - Pop happens when dout_valid && dout_ready.
  - Simultaneous push and pop when full is allowed: the pop frees the slot and the push is accepted, with no overrun.
  - Push when full without a pop: the byte is dropped and overrun is set.
  - dout always shows the head entry. dout is don't-care while dout_valid = 0, but the design holds 0 after reset.
- Errors:
  - Both error flags are sticky until err_clr.
  - If err_clr and a new error event occur in the same cycle, the flag is set (set wins).
- Reset mid-frame discards any partial byte and all FIFO contents.
- Pointers are log2(FIFO_DEPTH)+1 bits so full and empty can be distinguished; arithmetic wraps modulo 2*FIFO_DEPTH.

Decomposition:
- Package nibble_link_pkg holds:
  - the FSM state enum {IDLE, HIGH};
  - the NIB_W = 4 and BYTE_W = 8 constants;
  - the convention that the link is inverted (~ applied at receive).
- One sub-module, nibble_link_fifo, parameterised on width and depth, contains the push/pop/full/empty logic. The FSM, synchroniser and error flags stay in the top level.

Test Plan:
- Reset: rst_n low mid-operation -> dout_valid = 0, overrun = 0, frame_err = 0 immediately, with no clk edge needed.
- Single byte:
  - stimulus: beat(first = 1, nib_n = 4'hA), then beat(first = 0, nib_n = 4'hC);
  - response: dout = 8'h35 with dout_valid high SYNC_STAGES+2 cycles after the second toggle.
- Backpressure and overrun:
  - stimulus: dout_ready = 0, send bytes 8'h11, 8'h22, 8'h33;
  - response: overrun = 1; after raising dout_ready, the pops return 8'h11 then 8'h22 and dout_valid drops.
- Timeout:
  - stimulus: low beat, then no strb for TIMEOUT+1 cycles;
  - response: frame_err = 1 and no push; a following full byte 8'h5A is received correctly.
- Framing: a high beat while in IDLE -> frame_err = 1 and no push. Two consecutive first = 1 beats followed by a high beat -> frame_err = 1, and the pushed byte uses the second low nibble.
- Error clear and full-FIFO push/pop:
  - err_clr pulse -> both flags are 0 the next cycle; with the FIFO full, a simultaneous push and pop leaves overrun = 0 and preserves order.
